// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : State encoding and bit-timing constants shared by the
//               single-byte I2C master and the slave_sda_generate responder.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Bus-level protocol phases; each non-idle state spans whole SCL bits
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    ADDR  = 4'd2,
    AACK  = 4'd3,
    WDATA = 4'd4,
    WACK  = 4'd5,
    RDATA = 4'd6,
    MNACK = 4'd7,
    STOP  = 4'd8
  } i2c_state_e;

  // Quarter positions inside one SCL bit
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int BITS_PER_BYTE = 8;

endpackage
`default_nettype wire

// File: rtl/i2c_qtr_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_qtr_gen
// Description : Divides clk into SCL quarter periods. Emits a one-cycle tick
//               on the last clk of each quarter plus the current quarter
//               index. A restart strobe realigns both counters so quarter 0
//               begins on the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_qtr_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart_i,
  output logic       tick_o,
  output logic [1:0] q_o
);

  localparam logic [9:0] LAST_CNT = 10'(CLK_DIV - 1);

  logic [9:0] cnt_q;
  logic [1:0] q_q;

  assign tick_o = (cnt_q == LAST_CNT);
  assign q_o    = q_q;

  // Quarter-period prescaler with a wrapping 2-bit quarter index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      q_q   <= 2'd0;
    end else if (restart_i) begin
      cnt_q <= '0;
      q_q   <= 2'd0;
    end else if (tick_o) begin
      cnt_q <= '0;
      q_q   <= q_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 10'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_ctrl
// Description : Single-byte I2C master. Generates START, 7-bit address + R/W,
//               one data byte (write or read) and STOP on an open-drain SDA.
//               All bus and host outputs are registered; they are computed
//               for the quarter that begins at the same clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  i2c_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] wdat_q, wdat_d;
  logic       rw_q, rw_d;
  logic       ack_smp_q, ack_smp_d;
  logic       nack_q, nack_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       tick_w;
  logic [1:0] q_w;
  logic [1:0] qn_w;
  logic       accept_w;

  // A start arriving on the done cycle is deliberately refused
  assign accept_w = start && (state_q == IDLE) && !done_q;
  assign qn_w     = q_w + 2'd1;

  i2c_qtr_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_qtr_gen (
    .clk       (clk),
    .reset     (reset),
    .restart_i (accept_w),
    .tick_o    (tick_w),
    .q_o       (q_w)
  );

  // Next-state and next-output computation, evaluated on quarter ticks
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    wdat_d    = wdat_q;
    rw_d      = rw_q;
    ack_smp_d = ack_smp_q;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (accept_w) begin
      state_d   = START;
      shreg_d   = {addr, rw};
      wdat_d    = wr_data;
      rw_d      = rw;
      bitcnt_d  = 3'd0;
      ack_smp_d = 1'b0;
      nack_d    = 1'b0;
      ack_err_d = 1'b0;
      busy_d    = 1'b1;
      scl_d     = 1'b1;
      sda_oe_d  = 1'b0;
    end else if (tick_w && (state_q != IDLE)) begin
      // Sample SDA on the last clk of the SCL-high first half
      if (q_w == Q2) begin
        if ((state_q == AACK) || (state_q == WACK)) begin
          ack_smp_d = sda_i;
        end
        if (state_q == RDATA) begin
          rd_data_d = {rd_data_q[6:0], sda_i};
        end
      end

      if (q_w != Q3) begin
        // Within a bit: only SCL moves, except the START/STOP SDA edges
        case (state_q)
          START: begin
            scl_d    = 1'b1;
            sda_oe_d = 1'b1;
          end
          STOP: begin
            scl_d    = 1'b1;
            sda_oe_d = (qn_w == Q1);
          end
          default: scl_d = qn_w[1];
        endcase
      end else begin
        // Bit boundary: choose the next bit and drive its SDA in q0
        scl_d = 1'b0;
        case (state_q)
          START: begin
            state_d  = ADDR;
            bitcnt_d = 3'd0;
            sda_oe_d = ~shreg_q[7];
          end
          ADDR: begin
            if (bitcnt_q == LAST_BIT) begin
              state_d  = AACK;
              sda_oe_d = 1'b0;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
          AACK: begin
            bitcnt_d = 3'd0;
            if (ack_smp_q) begin
              nack_d   = 1'b1;
              state_d  = STOP;
              sda_oe_d = 1'b1;
            end else if (!rw_q) begin
              state_d  = WDATA;
              shreg_d  = wdat_q;
              sda_oe_d = ~wdat_q[7];
            end else begin
              state_d  = RDATA;
              sda_oe_d = 1'b0;
            end
          end
          WDATA: begin
            if (bitcnt_q == LAST_BIT) begin
              state_d  = WACK;
              sda_oe_d = 1'b0;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
          WACK: begin
            nack_d   = nack_q | ack_smp_q;
            state_d  = STOP;
            sda_oe_d = 1'b1;
          end
          RDATA: begin
            sda_oe_d = 1'b0;
            if (bitcnt_q == LAST_BIT) begin
              state_d = MNACK;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
          MNACK: begin
            state_d  = STOP;
            sda_oe_d = 1'b1;
          end
          STOP: begin
            state_d   = IDLE;
            scl_d     = 1'b1;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            ack_err_d = nack_q;
          end
          default: begin
            state_d  = IDLE;
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
          end
        endcase
      end
    end
  end

  // State and registered outputs; reset releases the bus without a STOP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bitcnt_q  <= 3'd0;
      shreg_q   <= 8'd0;
      wdat_q    <= 8'd0;
      rw_q      <= 1'b0;
      ack_smp_q <= 1'b0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= 8'd0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      wdat_q    <= wdat_d;
      rw_q      <= rw_d;
      ack_smp_q <= ack_smp_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_master_ctrl
// Description : Self-checking bench for i2c_master_ctrl with a behavioural
//               open-drain slave and a bus monitor; expected frames are
//               queued at issue time and compared at done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = 7'd0;
  logic       rw = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       scl, sda_oe, busy, done, ack_err;
  logic [7:0] rd_data;
  logic       slave_oe = 1'b0;
  logic       sda_line;

  assign sda_line = ~(sda_oe | slave_oe);

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw),
    .wr_data(wr_data), .scl(scl), .sda_oe(sda_oe), .sda_i(sda_line),
    .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          lat;
    logic        aerr;
    logic [7:0]  rdat;
  } exp_t;

  exp_t exp_q[$];
  int   nerr = 0;
  int   nchk = 0;
  int   t_acc = 0;
  logic [7:0] model_rd = 8'd0;

  // slave configuration and monitor state
  bit          ack_a_cfg = 1'b1;
  bit          ack_d_cfg = 1'b1;
  bit          rw_cfg = 1'b0;
  logic [7:0]  rd_cfg = 8'd0;
  bit          mon_clr = 1'b0;
  logic [31:0] obs_bits = 0;
  int          obs_n = 0;
  int          n_start = 0;
  int          n_stop = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;

  // bus monitor and open-drain slave responder
  always @(negedge clk) begin
    logic line;
    int   nxt;
    line = ~(sda_oe | slave_oe);
    if (mon_clr) begin
      obs_bits = 0; obs_n = 0; n_start = 0; n_stop = 0; slave_oe = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !line) n_start++;
      if (prev_scl && scl && !prev_sda && line) begin
        n_stop++;
        slave_oe = 1'b0;
      end
      if (!prev_scl && scl) begin
        obs_bits = {obs_bits[30:0], line};
        obs_n++;
      end
      if (prev_scl && !scl) begin
        nxt = obs_n + 1;
        slave_oe = 1'b0;
        if (nxt == 9) slave_oe = ack_a_cfg;
        else if (nxt >= 10 && nxt <= 17 && rw_cfg && ack_a_cfg) slave_oe = ~rd_cfg[17-nxt];
        else if (nxt == 18 && !rw_cfg && ack_a_cfg) slave_oe = ack_d_cfg;
      end
    end
    prev_scl = scl;
    prev_sda = line;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, nerr=%0d", nerr);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [6:0] a, input logic r, input logic [7:0] w,
                          input bit aa, input bit ad, input logic [7:0] rb);
    exp_t e;
    logic [7:0] ab;
    ab = {a, r};
    e.bits = 0;
    e.nbits = 0;
    for (int i = 7; i >= 0; i--) begin e.bits = {e.bits[30:0], ab[i]}; e.nbits++; end
    e.bits = {e.bits[30:0], ~aa}; e.nbits++;
    if (aa) begin
      for (int i = 7; i >= 0; i--) begin e.bits = {e.bits[30:0], (r ? rb[i] : w[i])}; e.nbits++; end
      e.bits = {e.bits[30:0], (r ? 1'b1 : ~ad)}; e.nbits++;
      if (r) model_rd = rb;
    end
    e.bits = {e.bits[30:0], 1'b0}; e.nbits++;   // SCL rise inside STOP with SDA low
    e.lat  = aa ? 80*D : 44*D;
    e.aerr = !aa || (!r && !ad);
    e.rdat = model_rd;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w,
                       input bit aa, input bit ad, input logic [7:0] rb);
    ack_a_cfg = aa; ack_d_cfg = ad; rw_cfg = r; rd_cfg = rb;
    @(posedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    addr = a; rw = r; wr_data = w; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t_acc = cyc;
    push_exp(a, r, w, aa, ad, rb);
  endtask

  task automatic wait_done(output int lat, output bit ok);
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin ok = 1'b1; lat = cyc - t_acc; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    nchk++; if (scl !== 1'b1) begin nerr++; $display("FAIL reset_scl: got %b want 1", scl); end
    nchk++; if (sda_oe !== 1'b0) begin nerr++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
    nchk++; if (ack_err !== 1'b0) begin nerr++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    nchk++; if (rd_data !== 8'h00) begin nerr++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
  endtask

  task automatic test_write();
    exp_t e; int lat; bit ok;
    issue(7'h54, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL write_busy: got %b want 1", busy); end
    wait_done(lat, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok) begin nerr++; $display("FAIL write_timeout: done got 0 want 1"); end
    nchk++; if (lat != e.lat) begin nerr++; $display("FAIL write_latency: got %0d want %0d", lat, e.lat); end
    nchk++; if (obs_n != e.nbits || obs_bits !== e.bits) begin nerr++; $display("FAIL write_bits: got %0d/%h want %0d/%h", obs_n, obs_bits, e.nbits, e.bits); end
    nchk++; if (ack_err !== e.aerr) begin nerr++; $display("FAIL write_ack_err: got %b want %b", ack_err, e.aerr); end
    nchk++; if (rd_data !== e.rdat) begin nerr++; $display("FAIL write_rd_data: got %h want %h", rd_data, e.rdat); end
    nchk++; if (n_start != 1 || n_stop != 1) begin nerr++; $display("FAIL write_start_stop: got %0d/%0d want 1/1", n_start, n_stop); end
    @(posedge clk); #1;
    nchk++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL write_done_pulse: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_read();
    exp_t e; int lat; bit ok;
    issue(7'h54, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA8);
    wait_done(lat, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok) begin nerr++; $display("FAIL read_timeout: done got 0 want 1"); end
    nchk++; if (lat != e.lat) begin nerr++; $display("FAIL read_latency: got %0d want %0d", lat, e.lat); end
    nchk++; if (obs_n != e.nbits || obs_bits !== e.bits) begin nerr++; $display("FAIL read_bits: got %0d/%h want %0d/%h", obs_n, obs_bits, e.nbits, e.bits); end
    nchk++; if (ack_err !== e.aerr) begin nerr++; $display("FAIL read_ack_err: got %b want %b", ack_err, e.aerr); end
    nchk++; if (rd_data !== e.rdat) begin nerr++; $display("FAIL read_rd_data: got %h want %h", rd_data, e.rdat); end
    nchk++; if (n_start != 1 || n_stop != 1) begin nerr++; $display("FAIL read_start_stop: got %0d/%0d want 1/1", n_start, n_stop); end
  endtask

  task automatic test_addr_nack();
    exp_t e; int lat; bit ok;
    issue(7'h2A, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h00);
    wait_done(lat, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok) begin nerr++; $display("FAIL anack_timeout: done got 0 want 1"); end
    nchk++; if (lat != e.lat) begin nerr++; $display("FAIL anack_latency: got %0d want %0d", lat, e.lat); end
    nchk++; if (obs_n != e.nbits || obs_bits !== e.bits) begin nerr++; $display("FAIL anack_bits: got %0d/%h want %0d/%h", obs_n, obs_bits, e.nbits, e.bits); end
    nchk++; if (ack_err !== e.aerr) begin nerr++; $display("FAIL anack_ack_err: got %b want %b", ack_err, e.aerr); end
    nchk++; if (rd_data !== e.rdat) begin nerr++; $display("FAIL anack_rd_data: got %h want %h", rd_data, e.rdat); end
    nchk++; if (n_start != 1 || n_stop != 1) begin nerr++; $display("FAIL anack_start_stop: got %0d/%0d want 1/1", n_start, n_stop); end
  endtask

  task automatic test_data_nack();
    exp_t e; int lat; bit ok;
    issue(7'h13, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00);
    wait_done(lat, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok) begin nerr++; $display("FAIL dnack_timeout: done got 0 want 1"); end
    nchk++; if (lat != e.lat) begin nerr++; $display("FAIL dnack_latency: got %0d want %0d", lat, e.lat); end
    nchk++; if (obs_n != e.nbits || obs_bits !== e.bits) begin nerr++; $display("FAIL dnack_bits: got %0d/%h want %0d/%h", obs_n, obs_bits, e.nbits, e.bits); end
    nchk++; if (ack_err !== e.aerr) begin nerr++; $display("FAIL dnack_ack_err: got %b want %b", ack_err, e.aerr); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit ok;
    issue(7'h2A, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    repeat (50) @(posedge clk);
    #1 addr = 7'h11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy_mid: got %b want 1", busy); end
    wait_done(lat, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok) begin nerr++; $display("FAIL b2b_timeout1: done got 0 want 1"); end
    nchk++; if (lat != e.lat) begin nerr++; $display("FAIL b2b_latency1: got %0d want %0d", lat, e.lat); end
    nchk++; if (obs_n != e.nbits || obs_bits !== e.bits) begin nerr++; $display("FAIL b2b_bits1: got %0d/%h want %0d/%h", obs_n, obs_bits, e.nbits, e.bits); end
    // start raised during the done cycle and held one more cycle
    ack_a_cfg = 1'b1; ack_d_cfg = 1'b1; rw_cfg = 1'b0;
    mon_clr = 1'b1;
    addr = 7'h54; rw = 1'b0; wr_data = 8'hC3; start = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    @(posedge clk); #1;
    nchk++; if (busy !== 1'b0 || ack_err !== 1'b1) begin nerr++; $display("FAIL b2b_done_cycle: got busy=%b ack_err=%b want 0/1", busy, ack_err); end
    @(posedge clk); #1 start = 1'b0;
    t_acc = cyc;
    nchk++; if (busy !== 1'b1 || ack_err !== 1'b0) begin nerr++; $display("FAIL b2b_accept: got busy=%b ack_err=%b want 1/0", busy, ack_err); end
    push_exp(7'h54, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00);
    wait_done(lat, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok) begin nerr++; $display("FAIL b2b_timeout2: done got 0 want 1"); end
    nchk++; if (lat != e.lat) begin nerr++; $display("FAIL b2b_latency2: got %0d want %0d", lat, e.lat); end
    nchk++; if (obs_n != e.nbits || obs_bits !== e.bits) begin nerr++; $display("FAIL b2b_bits2: got %0d/%h want %0d/%h", obs_n, obs_bits, e.nbits, e.bits); end
    nchk++; if (ack_err !== e.aerr) begin nerr++; $display("FAIL b2b_ack_err2: got %b want %b", ack_err, e.aerr); end
  endtask

  task automatic test_mid_reset();
    exp_t e; int lat; bit ok;
    issue(7'h54, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    e = exp_q.pop_front();            // aborted transaction has no outcome
    repeat (200) @(posedge clk);      // inside WDATA bit 3
    #3 reset = 1'b1;
    #1;
    nchk++; if (scl !== 1'b1) begin nerr++; $display("FAIL mrst_scl: got %b want 1", scl); end
    nchk++; if (sda_oe !== 1'b0) begin nerr++; $display("FAIL mrst_sda_oe: got %b want 0", sda_oe); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL mrst_busy: got %b want 0", busy); end
    nchk++; if (rd_data !== 8'h00) begin nerr++; $display("FAIL mrst_rd_data: got %h want 00", rd_data); end
    model_rd = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    issue(7'h3C, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00);
    wait_done(lat, ok);
    e = exp_q.pop_front();
    nchk++; if (!ok) begin nerr++; $display("FAIL mrst_timeout: done got 0 want 1"); end
    nchk++; if (lat != e.lat) begin nerr++; $display("FAIL mrst_latency: got %0d want %0d", lat, e.lat); end
    nchk++; if (obs_n != e.nbits || obs_bits !== e.bits) begin nerr++; $display("FAIL mrst_bits: got %0d/%h want %0d/%h", obs_n, obs_bits, e.nbits, e.bits); end
    nchk++; if (ack_err !== e.aerr) begin nerr++; $display("FAIL mrst_ack_err: got %b want %b", ack_err, e.aerr); end
    nchk++; if (rd_data !== e.rdat) begin nerr++; $display("FAIL mrst_rd_data2: got %h want %h", rd_data, e.rdat); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C master. It is the initiator for the slave_sda_generate responder: it generates SCL and the START/STOP conditions, shifts out the 7-bit address plus R/W, then writes or reads one data byte.
- SDA is modelled open-drain: the block only ever pulls the line low, and the top level or bench supplies the pull-up.
- A host issues one transaction per start pulse and gets done, ack_err and rd_data back.

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period; legal range 2 to 1023; one SCL bit is 4*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- addr  in  7  slave address, sent MSB first.
- rw  in  1  0 = write, 1 = read; appended as the 8th address bit.
- wr_data  in  8  byte to write, sent MSB first.
- scl  out  1  I2C clock, push-pull.
- sda_oe  out  1  1 = pull SDA low, 0 = release SDA to high.
- sda_i  in  1  resolved SDA line level.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the transaction completes.
- ack_err  out  1  set with done if any expected slave ACK was missing; held until the next accepted start.
- rd_data  out  8  byte read; valid from done until the next accepted start.

Behaviour:
- Reset values:
  - scl=1, sda_oe=0, busy=0, done=0, ack_err=0, rd_data=0.
  - State IDLE, quarter counter and bit counter = 0.
- Reset asserted mid-transaction: all outputs return to reset values immediately. This releases the bus with no STOP generated.
- Start acceptance: on a start pulse in IDLE, the block latches {addr,rw} and wr_data, and clears ack_err.
- Timing base: a tick pulses every CLK_DIV clk cycles. The quarter index q runs 0..3 and advances on each tick.
- Data bit timing:
  - q0: scl=0, SDA updated.
  - q1: scl=0.
  - q2: scl=1; sda_i sampled on the last clk of q2.
  - q3: scl=1.
- States, each occupying 4 quarters per bit:
  - IDLE: scl=1, sda released.
  - START: q0 sda released, scl=1; q1 to q3 sda low, scl=1 (SDA falls while SCL is high); then ADDR.
  - ADDR: 8 bits, {addr,rw} MSB first; then AACK.
  - AACK: sda released. If the sample is 1, set ack_err and go to STOP. Otherwise go to WDATA when rw=0, or RDATA when rw=1.
  - WDATA: 8 bits of wr_data; then WACK.
  - WACK: sda released; if the sample is 1, set ack_err; then STOP.
  - RDATA: sda released; 8 samples shifted into rd_data MSB first; then MNACK.
  - MNACK: master leaves sda released (NACK, last byte); then STOP.
  - STOP: q0 scl=0, sda low; q1 scl=1, sda low; q2 and q3 scl=1, sda released (SDA rises while SCL is high); then done=1 for one clk and return to IDLE.
- Latency with full ACK: START + 9 + 9 + STOP = 20 bit-times = 80*CLK_DIV clk cycles from the accepting clk to the done pulse.
- Latency with an address NACK: 11 bit-times = 44*CLK_DIV clk cycles.
- start while busy=1 is ignored, with no queuing. start arriving in the same cycle as done is ignored; it is accepted one cycle later.
- sda_oe changes only in q0 of a bit, except in START and STOP. SDA never changes while scl=1 except at START and STOP edges.
- rd_data is updated only by RDATA.

Decomposition:
- Package i2c_pkg:
  - State enum: IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP.
  - Quarter constants Q0 to Q3, and BITS_PER_BYTE=8.
  - Shared with slave_sda_generate.
- Sub-module i2c_qtr_gen: CLK_DIV counter producing the tick and the 2-bit q index. It is reset synchronously by a restart strobe so that START q0 begins on the cycle after acceptance.

Test Plan:
- Write with ACK (CLK_DIV=4):
  - Stimulus: addr=7'h54, rw=0, wr_data=8'hA5, slave model ACKs.
  - Required: SDA bits 1,0,1,0,1,0,0,0 / ACK / 1,0,1,0,0,1,0,1 / ACK; START and STOP edges correct.
  - Required: done exactly 320 clk after acceptance; ack_err=0.
- Read:
  - Stimulus: addr=7'h54, rw=1, slave returns 8'hA8.
  - Required: rd_data=8'hA8 at done; master NACK seen (SDA high during SCL-high of bit 9); ack_err=0.
- Address NACK:
  - Stimulus: slave never pulls low.
  - Required: STOP straight after AACK; done 176 clk after acceptance; ack_err=1; WDATA never entered.
- Data NACK:
  - Stimulus: write where the slave ACKs the address and NACKs the data.
  - Required: ack_err=1 and done at 320 clk.
- Busy and back-to-back starts:
  - Stimulus: start pulsed mid-transaction, and start pulsed on the done cycle.
  - Required: both ignored; a start one cycle after done is accepted and clears ack_err.
- Mid-transaction reset:
  - Stimulus: reset asserted during bit 3 of WDATA.
  - Required: scl=1, sda_oe=0, busy=0 immediately (asynchronous); a next start runs a normal transaction.
